// File: rtl/nibble_serial_addsub_ctrl_if.sv
// ---------------------------------------------------------------------------
// nibble_serial_addsub_ctrl_if
// Bus between the processor control unit (master) and the nibble-serial
// add/sub sequencer (slave).
//   start  : operation request, sampled by the sequencer only when idle
//   op     : 0 = A+B, 1 = A-B
//   a, b   : operands, captured on an accepted start
//   busy   : nibbles being processed
//   done   : one-cycle pulse, result/flags valid
//   result : sum/difference, held until the next accepted start
//   cout   : final carry-out (subtract: 1 = no borrow)
//   ovf    : signed two's-complement overflow
//   zero   : result == 0
// ---------------------------------------------------------------------------
interface nibble_serial_addsub_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int WIDTH = 4 * NIBBLES;

  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, cout, ovf, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, cout, ovf, zero
  );
endinterface

// File: rtl/nibble_serial_addsub_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_addsub_ctrl
// WIDTH-bit (WIDTH = 4*NIBBLES) add/subtract performed by time-sharing one
// 4-bit add/sub slice over the operand nibbles, LSB nibble first. Subtract
// uses two's complement: B is inverted and the chained carry starts at 1.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of nibble_serial_addsub_ctrl_if (start/op/a/b in,
//           busy/done/result/cout/ovf/zero out, all outputs registered)
// Timing: start sampled on edge E0, nibbles on E1..E_NIBBLES, done high for
// one cycle after E_NIBBLES, back to IDLE on the following edge.
// ---------------------------------------------------------------------------
module nibble_serial_addsub_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  nibble_serial_addsub_ctrl_if.slave   bus
);

  localparam int WIDTH = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   result_q;
  logic               cout_q;
  logic               ovf_q;
  logic               zero_q;

  // Operand latches carry no reset: they are only ever read in RUN, which
  // can only be reached through the capture path that loads them.
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               op_q;

  // 5-bit unsigned nibble add with carry-in; bit 4 is the nibble carry.
  function automatic logic [4:0] nib_add(input logic [3:0] x,
                                         input logic [3:0] y,
                                         input logic       ci);
    return {1'b0, x} + {1'b0, y} + {4'b0000, ci};
  endfunction

  logic [IDX_W+1:0]   nib_sh;
  logic [3:0]         a_nib;
  logic [3:0]         bx_nib;
  logic [4:0]         nib_sum;
  logic [WIDTH-1:0]   result_ins;
  logic               bx_msb;
  logic               ovf_fin;

  // ---- slice datapath: select current nibble, add, merge into result ----
  always_comb begin
    nib_sh     = {idx_q, 2'b00};
    a_nib      = 4'(a_q >> nib_sh);
    bx_nib     = 4'(b_q >> nib_sh) ^ {4{op_q}};
    nib_sum    = nib_add(a_nib, bx_nib, carry_q);
    result_ins = (result_q & ~(WIDTH'(4'hF) << nib_sh))
               | (WIDTH'(nib_sum[3:0]) << nib_sh);
    // Signed overflow on the full word: operands (after conditional
    // inversion) share a sign that the final sum bit disagrees with.
    bx_msb     = b_q[WIDTH-1] ^ op_q;
    ovf_fin    = (a_q[WIDTH-1] == bx_msb) && (nib_sum[3] != a_q[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.start) begin
      a_q  <= bus.a;
      b_q  <= bus.b;
      op_q <= bus.op;
    end
  end

  // ---- sequencer FSM with registered handshake and flag outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            // Flags hold their previous values until the new DONE.
            carry_q  <= bus.op;
            idx_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end

        RUN: begin
          result_q <= result_ins;
          carry_q  <= nib_sum[4];
          if (idx_q == LAST_IDX) begin
            // idx stays at the last nibble; only a new capture rewinds it.
            cout_q  <= nib_sum[4];
            ovf_q   <= ovf_fin;
            zero_q  <= (result_ins == '0);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = zero_q;

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_addsub_ctrl
// Scoreboard bench: a word-level add/sub model produces the expected
// result/flags when an operation is driven; a monitor pops and compares on
// every done pulse. Handshake timing, hold behaviour and asynchronous reset
// are checked directly by the driving process.
// ---------------------------------------------------------------------------
module tb_nibble_serial_addsub_ctrl;

  localparam int NIBBLES = 4;
  localparam int WIDTH   = 4 * NIBBLES;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             co;
    logic             ov;
    logic             z;
  } exp_t;

  logic clk;
  logic rst_n;

  nibble_serial_addsub_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

  nibble_serial_addsub_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b);
    exp_t             e;
    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   full;
    bx   = op ? (~b) : b;
    full = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, op};
    e.res = full[WIDTH-1:0];
    e.co  = full[WIDTH];
    e.ov  = (a[WIDTH-1] == bx[WIDTH-1]) && (e.res[WIDTH-1] != a[WIDTH-1]);
    e.z   = (e.res == '0);
    return e;
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        chk("extra_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("result", 32'(bus.result), 32'(mon_e.res));
        chk("cout",   32'(bus.cout),   32'(mon_e.co));
        chk("ovf",    32'(bus.ovf),    32'(mon_e.ov));
        chk("zero",   32'(bus.zero),   32'(mon_e.z));
      end
    end
  end

  task automatic run_op(input logic op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b);
    int   n;
    int   nbusy;
    exp_t e;
    e = model(op, a, b);
    @(negedge clk);
    bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    // Post-capture input changes must not disturb the operation.
    bus.start = 1'b0; bus.a = 16'hDEAD; bus.b = 16'hBEEF; bus.op = ~op;
    n = 0; nbusy = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (bus.busy) nbusy++;
      if (bus.done) break;
    end
    chk("latency",      32'(n),        32'd5);
    chk("busy_cycles",  32'(nbusy),    32'd4);
    chk("busy_at_done", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(bus.done),   32'd0);
    chk("hold_result",    32'(bus.result), 32'(e.res));
    chk("hold_zero",      32'(bus.zero),   32'(e.z));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int first;
    int second;
    int d0;
    rst_n = 1'b1;
    bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy",   32'(bus.busy),   32'd0);
    chk("rst_done",   32'(bus.done),   32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_flags",  32'({bus.cout, bus.ovf, bus.zero}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(1'b0, 16'h1234, 16'h0FCD);   // 0x2201
    run_op(1'b1, 16'h5000, 16'h0001);   // 0x4FFF, no borrow
    run_op(1'b1, 16'h0003, 16'h0005);   // 0xFFFE, borrow
    run_op(1'b0, 16'h7FFF, 16'h0001);   // 0x8000, ovf
    run_op(1'b0, 16'hFFFF, 16'h0001);   // 0x0000, cout, zero
    run_op(1'b1, 16'h8000, 16'h0001);   // 0x7FFF, ovf, cout

    // Asynchronous reset two RUN cycles into an operation.
    @(negedge clk);
    bus.op = 1'b0; bus.a = 16'h1234; bus.b = 16'h0FCD; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_busy",   32'(bus.busy),   32'd0);
    chk("midrst_done",   32'(bus.done),   32'd0);
    chk("midrst_result", 32'(bus.result), 32'd0);
    chk("midrst_cout",   32'(bus.cout),   32'd0);
    chk("midrst_ovf",    32'(bus.ovf),    32'd0);
    chk("midrst_zero",   32'(bus.zero),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 16'h0001, 16'h0001);   // 0x0002

    // start held high: operands change during RUN/DONE, restart on IDLE.
    d0 = done_cnt;
    @(negedge clk);
    bus.op = 1'b0; bus.a = 16'h1111; bus.b = 16'h2222; bus.start = 1'b1;
    sb_q.push_back(model(1'b0, 16'h1111, 16'h2222));
    sb_q.push_back(model(1'b0, 16'hAAAA, 16'h5555));
    @(posedge clk);
    #1 bus.a = 16'hAAAA; bus.b = 16'h5555;
    k = 0; first = -1; second = -1;
    while (k < 40 && second < 0) begin
      @(negedge clk);
      k++;
      if (bus.done) begin
        if (first < 0) first = k;
        else begin
          second = k;
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    chk("hs_first_latency", 32'(first),          32'd5);
    chk("hs_throughput",    32'(second - first), 32'd6);
    repeat (10) @(negedge clk);
    chk("hs_done_count",    32'(done_cnt - d0),  32'd2);
    chk("sb_empty",         32'(sb_q.size()),    32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
